loot_field_controller: RTL and testbench
========================================

Name: loot_field_controller

Overview:
- Owns the loot slots on the playfield: type and top-left position of each slot.
- Drives the bitmap-drawer side of the loot interface with loot_type, offsetX, offsetY and InsideRectangle for every scanned pixel.
- Spawns loot at level start, either by LFSR or by explicit preload.
- Answers hook grab requests by removing the hit slot and reporting its type to game logic.

Parameters:
- NUM_SLOTS, 8, number of loot slots (1..8); slot index width is 3.
- TILE_BITS, 5, tile is (1<<TILE_BITS) square pixels; must match the bitmap drawer.
- FIELD_X0, 64, left edge of the random spawn area in pixels.
- FIELD_Y0, 160, top edge of the random spawn area in pixels.
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-low
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- level_start  in  1  pulse; begin random spawn of all slots
- load_en  in  1  pulse; direct-write one slot
- load_idx  in  3  slot written by load_en
- load_x  in  11  top-left X written by load_en
- load_y  in  11  top-left Y written by load_en
- load_type  in  3  type written by load_en (0 = empty)
- grab_req  in  1  pulse; hook tip is probing
- grab_x  in  11  hook tip X
- grab_y  in  11  hook tip Y
- loot_type  out  3  type under the pixel (0 = none)
- offsetX  out  11  pixelX minus the hit slot's X
- offsetY  out  11  pixelY minus the hit slot's Y
- InsideRectangle  out  1  pixel lies inside an occupied slot tile
- grab_ack  out  1  one-cycle response to grab_req
- grabbed_type  out  3  type removed by the grab (0 = miss); valid with grab_ack
- loot_remaining  out  4  count of occupied slots
- field_ready  out  1  high in READY state

Behaviour:
- Reset: all outputs are 0, every slot type is 0, every slot X/Y is 0, the LFSR holds LFSR_SEED, and the FSM is in IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every clock in every state, never pauses, and never reaches 0.

Pixel path (1-cycle registered latency):
- A slot hits when its type != 0, pixelX - x is in 0..(1<<TILE_BITS)-1, and pixelY - y is in the same range.
- Compare unsigned on 11 bits, so a pixel above or left of the slot underflows and misses.
- The lowest-index hitting slot wins.
- On a hit, the next cycle shows InsideRectangle=1, loot_type = slot type, and offsetX/offsetY = the 11-bit differences.
- With no hit, all four pixel outputs are 0 on the next cycle.
- The pixel path runs in every FSM state.

FSM: IDLE -> SPAWN -> READY.
- IDLE: the pixel path uses the current slots. level_start goes to SPAWN with the slot counter at 0.
- SPAWN: one slot per cycle. Slot k gets:
  - x = FIELD_X0 + lfsr[8:0]
  - y = FIELD_Y0 + {lfsr[15:9],1'b0}
  - type = lfsr[10] ? 1 (gold) : 2 (stone)
  - After slot NUM_SLOTS-1 is written, the next state is READY. SPAWN lasts exactly NUM_SLOTS cycles.
- READY: field_ready=1. level_start re-enters SPAWN, and every slot is overwritten.
- Slots may overlap; the pixel path and the grab path both give priority to the lowest index.

Direct load:
- load_en writes slot load_idx in IDLE or READY, effective the next cycle.
- load_en is ignored in SPAWN.
- load_idx >= NUM_SLOTS is ignored.
- load_en does not change the FSM state.

Grab:
- grab_req is accepted only in READY; in other states it is dropped with no grab_ack.
- Cycle N: grab_req is sampled together with grab_x/grab_y. The same hit test runs against (grab_x, grab_y).
- Cycle N+1: grab_ack=1 and grabbed_type = hit type, or 0 on a miss. The hit slot's type is cleared to 0 on this same edge.
- A grab_req that arrives while a previous ack is pending is dropped.
- A grab_req coinciding with level_start: level_start wins and the grab is dropped.
- A grab_req coinciding with a load_en to the same slot: the grab wins, and the slot ends at type 0.

loot_remaining:
- Registered popcount of slots with type != 0.
- Updates one cycle after any slot change.

Reset mid-SPAWN: returns to IDLE with all slots empty.

Test Plan:
- Reset, then preload slot0 = (100, 200, type 1); pixel (100,200) -> next cycle InsideRectangle=1, loot_type=1, offset (0,0). Pixel (131,231) -> offset (31,31). Pixel (132,200) -> InsideRectangle=0. Pixel (99,200) -> InsideRectangle=0 (underflow).
- Preload slot2 = (100,200,2) and slot5 = (110,210,1); pixel (115,215) -> loot_type=2, offset (15,15).
- level_start with NUM_SLOTS=8: field_ready rises exactly 8 cycles later; loot_remaining=8. Every X is in 64..575, every Y is even and in 160..414, and every type is in {1,2}, matching the bench LFSR model.
- In READY with slot0 = (100,200,1): grab_req at (105,210) -> grab_ack with grabbed_type=1 one cycle later. loot_remaining goes 8 -> 7. A repeat grab at the same point -> grabbed_type=0.
- grab_req during SPAWN -> no grab_ack. grab_req together with level_start -> no grab_ack, and SPAWN restarts.
- Assert resetN low midway through SPAWN -> all outputs 0 and loot_remaining=0. A pixel over a previously spawned slot then gives InsideRectangle=0.

Source files
------------

// File: rtl/loot_field_controller.sv
// Loot slot table: LFSR/preload spawn, per-pixel hit lookup and hook grab removal.
// Pixel outputs, grab response and loot count are all registered (1-cycle latency).
module loot_field_controller #(
  parameter int          NUM_SLOTS = 8,
  parameter int          TILE_BITS = 5,
  parameter int          FIELD_X0  = 64,
  parameter int          FIELD_Y0  = 160,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        level_start,
  input  logic        load_en,
  input  logic [2:0]  load_idx,
  input  logic [10:0] load_x,
  input  logic [10:0] load_y,
  input  logic [2:0]  load_type,
  input  logic        grab_req,
  input  logic [10:0] grab_x,
  input  logic [10:0] grab_y,
  output logic [2:0]  loot_type,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        grab_ack,
  output logic [2:0]  grabbed_type,
  output logic [3:0]  loot_remaining,
  output logic        field_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPAWN = 2'd1, READY = 2'd2} state_t;

  localparam logic [10:0] TILE = 11'(1 << TILE_BITS);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [2:0]  slot_t_q [NUM_SLOTS];
  logic [2:0]  slot_t_d [NUM_SLOTS];
  logic [10:0] slot_x_q [NUM_SLOTS];
  logic [10:0] slot_x_d [NUM_SLOTS];
  logic [10:0] slot_y_q [NUM_SLOTS];
  logic [10:0] slot_y_d [NUM_SLOTS];

  logic [2:0]  loot_type_q;
  logic [10:0] offx_q, offy_q;
  logic        inside_q;
  logic        grab_ack_q;
  logic [2:0]  grabbed_type_q;
  logic [3:0]  remain_q, remain_d;

  logic [10:0] p_dx [NUM_SLOTS];
  logic [10:0] p_dy [NUM_SLOTS];
  logic [10:0] g_dx [NUM_SLOTS];
  logic [10:0] g_dy [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] p_hit, g_hit;

  logic        p_any, g_any;
  logic [2:0]  p_type, g_type, g_idx;
  logic [10:0] p_offx, p_offy;
  logic        grab_acc;
  logic [10:0] spawn_x, spawn_y;
  logic [2:0]  spawn_t;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Unsigned 11-bit differences: points above/left of a slot wrap high and miss.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      p_dx[i]  = pixelX - slot_x_q[i];
      p_dy[i]  = pixelY - slot_y_q[i];
      g_dx[i]  = grab_x - slot_x_q[i];
      g_dy[i]  = grab_y - slot_y_q[i];
      p_hit[i] = (slot_t_q[i] != 3'd0) && (p_dx[i] < TILE) && (p_dy[i] < TILE);
      g_hit[i] = (slot_t_q[i] != 3'd0) && (g_dx[i] < TILE) && (g_dy[i] < TILE);
    end
  end

  // Scan from the top so the lowest-index hit is the last one assigned.
  always_comb begin
    p_any  = 1'b0;
    p_type = 3'd0;
    p_offx = 11'd0;
    p_offy = 11'd0;
    g_any  = 1'b0;
    g_type = 3'd0;
    g_idx  = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (p_hit[i]) begin
        p_any  = 1'b1;
        p_type = slot_t_q[i];
        p_offx = p_dx[i];
        p_offy = p_dy[i];
      end
      if (g_hit[i]) begin
        g_any  = 1'b1;
        g_type = slot_t_q[i];
        g_idx  = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, READY: begin
        if (level_start) begin
          state_d = SPAWN;
          cnt_d   = 3'd0;
        end
      end
      SPAWN: begin
        if (cnt_q == 3'(NUM_SLOTS - 1)) state_d = READY;
        else                            cnt_d   = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grab_acc = (state_q == READY) && grab_req && !level_start && !grab_ack_q;

  assign spawn_x = 11'(FIELD_X0) + {2'b00, lfsr_q[8:0]};
  assign spawn_y = 11'(FIELD_Y0) + {3'b000, lfsr_q[15:9], 1'b0};
  assign spawn_t = lfsr_q[10] ? 3'd1 : 3'd2;

  // Grab clear is applied after the load write so it wins on a shared slot.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_t_d[i] = slot_t_q[i];
      slot_x_d[i] = slot_x_q[i];
      slot_y_d[i] = slot_y_q[i];
      if (state_q == SPAWN) begin
        if (cnt_q == 3'(i)) begin
          slot_t_d[i] = spawn_t;
          slot_x_d[i] = spawn_x;
          slot_y_d[i] = spawn_y;
        end
      end else if (load_en && (load_idx == 3'(i))) begin
        slot_t_d[i] = load_type;
        slot_x_d[i] = load_x;
        slot_y_d[i] = load_y;
      end
      if (grab_acc && g_any && (g_idx == 3'(i))) slot_t_d[i] = 3'd0;
    end
  end

  always_comb begin
    remain_d = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_t_q[i] != 3'd0) remain_d = remain_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      lfsr_q         <= LFSR_SEED;
      loot_type_q    <= 3'd0;
      offx_q         <= 11'd0;
      offy_q         <= 11'd0;
      inside_q       <= 1'b0;
      grab_ack_q     <= 1'b0;
      grabbed_type_q <= 3'd0;
      remain_q       <= 4'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_t_q[i] <= 3'd0;
        slot_x_q[i] <= 11'd0;
        slot_y_q[i] <= 11'd0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lfsr_q         <= lfsr_d;
      loot_type_q    <= p_type;
      offx_q         <= p_offx;
      offy_q         <= p_offy;
      inside_q       <= p_any;
      grab_ack_q     <= grab_acc;
      grabbed_type_q <= grab_acc ? g_type : 3'd0;
      remain_q       <= remain_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_t_q[i] <= slot_t_d[i];
        slot_x_q[i] <= slot_x_d[i];
        slot_y_q[i] <= slot_y_d[i];
      end
    end
  end

  assign loot_type       = loot_type_q;
  assign offsetX         = offx_q;
  assign offsetY         = offy_q;
  assign InsideRectangle = inside_q;
  assign grab_ack        = grab_ack_q;
  assign grabbed_type    = grabbed_type_q;
  assign loot_remaining  = remain_q;
  assign field_ready     = (state_q == READY);

endmodule

// File: tb/tb_loot_field_controller.sv
// Directed bench for loot_field_controller: drives on negedge, checks on the following negedge.
module tb_loot_field_controller;
  localparam int NS = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        level_start = 1'b0, load_en = 1'b0, grab_req = 1'b0;
  logic [2:0]  load_idx = '0, load_type = '0;
  logic [10:0] load_x = '0, load_y = '0, grab_x = '0, grab_y = '0;
  logic [2:0]  loot_type, grabbed_type;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, grab_ack, field_ready;
  logic [3:0]  loot_remaining;

  int n_chk = 0;
  int n_fail = 0;

  logic [10:0] ex [NS];
  logic [10:0] ey [NS];
  logic [2:0]  et [NS];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  loot_field_controller dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .level_start(level_start), .load_en(load_en), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .load_type(load_type),
    .grab_req(grab_req), .grab_x(grab_x), .grab_y(grab_y),
    .loot_type(loot_type), .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .grab_ack(grab_ack),
    .grabbed_type(grabbed_type), .loot_remaining(loot_remaining),
    .field_ready(field_ready)
  );

  // Fibonacci LFSR with taps 16,14,13,11 (bit numbers 15,13,12,10), free-running from reset.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pv(input logic ins, input logic [2:0] t,
                                     input logic [10:0] dx, input logic [10:0] dy);
    return {6'd0, ins, t, dx, dy};
  endfunction

  function automatic int model_idx(input logic [10:0] px, input logic [10:0] py);
    logic [10:0] dx, dy;
    for (int j = 0; j < NS; j++) begin
      dx = px - ex[j];
      dy = py - ey[j];
      if (et[j] != 3'd0 && dx < 11'd32 && dy < 11'd32) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_pix(input logic [10:0] px, input logic [10:0] py);
    int j;
    j = model_idx(px, py);
    if (j < 0) return 32'd0;
    return pv(1'b1, et[j], px - ex[j], py - ey[j]);
  endfunction

  function automatic logic [31:0] model_pop();
    int c;
    c = 0;
    for (int j = 0; j < NS; j++) if (et[j] != 3'd0) c++;
    return 32'(c);
  endfunction

  function automatic logic [31:0] pix_obs();
    return {6'd0, InsideRectangle, loot_type, offsetX, offsetY};
  endfunction

  task automatic pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                     input logic [31:0] exp);
    pixelX = x;
    pixelY = y;
    @(negedge clk);
    check(tag, pix_obs(), exp);
  endtask

  task automatic load(input logic [2:0] idx, input logic [10:0] x, input logic [10:0] y,
                      input logic [2:0] t);
    load_en = 1'b1; load_idx = idx; load_x = x; load_y = y; load_type = t;
    @(negedge clk);
    load_en = 1'b0;
    ex[idx] = x; ey[idx] = y; et[idx] = t;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix"}, pix_obs(), 32'd0);
    check({tag, "_ack"}, {31'd0, grab_ack}, 32'd0);
    check({tag, "_gtype"}, {29'd0, grabbed_type}, 32'd0);
    check({tag, "_remain"}, {28'd0, loot_remaining}, 32'd0);
    check({tag, "_ready"}, {31'd0, field_ready}, 32'd0);
  endtask

  initial begin
    int h;
    logic [2:0] gexp;
    for (int j = 0; j < NS; j++) begin ex[j] = '0; ey[j] = '0; et[j] = '0; end

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    resetN = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Single slot, tile edges and underflow
    load(3'd0, 11'd100, 11'd200, 3'd1);
    pix("pix_origin", 11'd100, 11'd200, pv(1'b1, 3'd1, 11'd0, 11'd0));
    pix("pix_far_corner", 11'd131, 11'd231, pv(1'b1, 3'd1, 11'd31, 11'd31));
    pix("pix_right_out", 11'd132, 11'd200, 32'd0);
    pix("pix_left_underflow", 11'd99, 11'd200, 32'd0);
    pix("pix_bottom_out", 11'd100, 11'd232, 32'd0);
    check("remain_one", {28'd0, loot_remaining}, 32'd1);

    // Overlap priority
    load(3'd0, 11'd0, 11'd0, 3'd0);
    load(3'd2, 11'd100, 11'd200, 3'd2);
    load(3'd5, 11'd110, 11'd210, 3'd1);
    pix("pix_overlap_low_wins", 11'd115, 11'd215, pv(1'b1, 3'd2, 11'd15, 11'd15));
    pix("pix_slot5_only", 11'd135, 11'd235, pv(1'b1, 3'd1, 11'd25, 11'd25));
    check("remain_two", {28'd0, loot_remaining}, 32'd2);

    // Random spawn; grab and load during SPAWN are ignored
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      ex[k] = 11'd64 + {2'b00, m_lfsr[8:0]};
      ey[k] = 11'd160 + {3'b000, m_lfsr[15:9], 1'b0};
      et[k] = m_lfsr[10] ? 3'd1 : 3'd2;
      check($sformatf("spawn_busy_%0d", k), {31'd0, field_ready}, 32'd0);
      check($sformatf("spawn_no_ack_%0d", k), {31'd0, grab_ack}, 32'd0);
      grab_req = (k == 3);
      grab_x = ex[0]; grab_y = ey[0];
      load_en = (k == 6);
      load_idx = 3'd0; load_x = 11'd1000; load_y = 11'd1000; load_type = 3'd3;
      @(negedge clk);
    end
    grab_req = 1'b0;
    load_en = 1'b0;
    check("spawn_ready", {31'd0, field_ready}, 32'd1);
    @(negedge clk);
    check("spawn_remain", {28'd0, loot_remaining}, 32'd8);
    for (int k = 0; k < NS; k++)
      pix($sformatf("spawn_probe_%0d", k), ex[k], ey[k], model_pix(ex[k], ey[k]));
    pix("spawn_load_ignored", 11'd1000, 11'd1000, 32'd0);

    // Grab hit, then a held repeat grab (second cycle dropped while ack pending)
    load(3'd0, 11'd100, 11'd200, 3'd1);
    grab_req = 1'b1; grab_x = 11'd105; grab_y = 11'd210;
    @(negedge clk);
    grab_req = 1'b0;
    check("grab_ack", {31'd0, grab_ack}, 32'd1);
    check("grab_type", {29'd0, grabbed_type}, 32'd1);
    et[0] = 3'd0;
    @(negedge clk);
    check("grab_ack_drop", {31'd0, grab_ack}, 32'd0);
    check("grab_remain", {28'd0, loot_remaining}, 32'd7);

    h = model_idx(11'd105, 11'd210);
    gexp = (h < 0) ? 3'd0 : et[h];
    grab_req = 1'b1;
    @(negedge clk);
    check("regrab_ack", {31'd0, grab_ack}, 32'd1);
    check("regrab_type", {29'd0, grabbed_type}, {29'd0, gexp});
    if (h >= 0) et[h] = 3'd0;
    @(negedge clk);
    grab_req = 1'b0;
    check("regrab_pending_drop", {31'd0, grab_ack}, 32'd0);
    check("regrab_remain", {28'd0, loot_remaining}, model_pop());

    // Grab and load on the same slot in one cycle: grab wins
    h = model_idx(ex[1], ey[1]);
    gexp = (h < 0) ? 3'd0 : et[h];
    grab_req = 1'b1; grab_x = ex[1]; grab_y = ey[1];
    load(3'd1, ex[1], ey[1], 3'd3);
    grab_req = 1'b0;
    if (h >= 0) et[h] = 3'd0;
    check("grab_load_ack", {31'd0, grab_ack}, 32'd1);
    check("grab_load_type", {29'd0, grabbed_type}, {29'd0, gexp});
    pix("grab_load_pix", ex[1], ey[1], model_pix(ex[1], ey[1]));
    check("grab_load_remain", {28'd0, loot_remaining}, model_pop());

    // Grab together with level_start: dropped, SPAWN restarts; then reset mid-SPAWN
    grab_req = 1'b1; grab_x = ex[2]; grab_y = ey[2];
    level_start = 1'b1;
    @(negedge clk);
    grab_req = 1'b0;
    level_start = 1'b0;
    check("grab_vs_start_ready", {31'd0, field_ready}, 32'd0);
    @(negedge clk);
    check("grab_vs_start_no_ack", {31'd0, grab_ack}, 32'd0);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check_all_zero("mid_spawn_reset");
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    pix("after_reset_pix", ex[3], ey[3], 32'd0);
    check("after_reset_idle", {31'd0, field_ready}, 32'd0);
    grab_req = 1'b1; grab_x = ex[3]; grab_y = ey[3];
    @(negedge clk);
    grab_req = 1'b0;
    check("idle_grab_no_ack", {31'd0, grab_ack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
